// File: rtl/cp0_timer.sv
// cp0_timer: coprocessor 0 for the P7 pipeline. It sits at M, beside the data memory.
// It holds SR, Cause, EPC and PRId and takes NUM_HWINT level-sensitive interrupt
// lines. It arbitrates interrupt > exception > eret and produces the redirect
// target on epc_out.
// Optional feature: define CP0_TIMER_EN to add the Count/Compare timer.
// The timer interrupt (TI) is ORed into IP[15].
module cp0_timer #(
  parameter int          NUM_HWINT = 6,            // legal 1..6
  parameter logic [31:0] PRID_VAL  = 32'h2023_1198,
  parameter int          COUNT_DIV = 1             // legal 1..256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           CP0_addr,
  input  logic [31:0]          CP0_data_in,
  input  logic                 CP0_WE,
  input  logic [31:0]          pc_M_in,
  input  logic                 bd_M,
  input  logic [4:0]           ExcCode_in,
  input  logic                 eret_M,
  input  logic [NUM_HWINT-1:0] HWInt,
  output logic                 Req,
  output logic                 IntReq_out,
  output logic                 IntReq_reg_out,
  output logic [31:0]          epc_out,
  output logic [31:0]          CP0_data_out
);

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_SR      = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;
  localparam logic [4:0] A_PRID    = 5'd15;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exc_code;
  } cause_t;

  sr_t         sr_q;
  cause_t      cause_q;
  logic [31:0] epc_q;
  logic        int_req_q;

  logic [5:0]  pend;
  logic        ti;
  logic        int_req;
  logic        exc_req;
  logic        wr_en;
  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] count_rd;
  logic [31:0] compare_rd;

  // Pending vector: external lines map onto IP[10+i]. Line 5 is shared with the timer.
  always_comb begin
    pend = '0;
    for (int i = 0; i < NUM_HWINT; i++) pend[i] = HWInt[i];
    pend[5] = pend[5] | ti;
  end

  assign int_req = (|(pend & sr_q.im)) & ~sr_q.exl & sr_q.ie;
  assign exc_req = (ExcCode_in != 5'd0) & ~sr_q.exl;

  assign IntReq_out     = int_req;
  assign Req            = int_req | exc_req;
  assign IntReq_reg_out = int_req_q;
  assign epc_out        = Req ? (bd_M ? pc_M_in - 32'd4 : pc_M_in) : epc_q;

  // mtc0 is squashed while a redirect is being taken.
  assign wr_en  = CP0_WE & ~Req;
  assign wr_sr  = wr_en & (CP0_addr == A_SR);
  assign wr_epc = wr_en & (CP0_addr == A_EPC);

  // Architectural state: arbitration first, then the mtc0 write.
  // A same-cycle SR write overrides eret clearing EXL.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q      <= '0;
      cause_q   <= '0;
      epc_q     <= '0;
      int_req_q <= 1'b0;
    end else begin
      cause_q.ip <= pend;
      int_req_q  <= int_req;
      if (int_req) begin
        cause_q.exc_code <= 5'd0;
        cause_q.bd       <= bd_M;
        sr_q.exl         <= 1'b1;
        epc_q            <= epc_out;
      end else if (exc_req) begin
        cause_q.exc_code <= ExcCode_in;
        cause_q.bd       <= bd_M;
        sr_q.exl         <= 1'b1;
        epc_q            <= epc_out;
      end else if (eret_M) begin
        sr_q.exl <= 1'b0;
      end
      if (wr_sr) begin
        sr_q.im  <= CP0_data_in[15:10];
        sr_q.exl <= CP0_data_in[1];
        sr_q.ie  <= CP0_data_in[0];
      end
      if (wr_epc) epc_q <= {CP0_data_in[31:2], 2'b00};
    end
  end

`ifdef CP0_TIMER_EN
  localparam logic [7:0] PRESC_LAST = 8'(COUNT_DIV - 1);

  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] count_nxt;
  logic [7:0]  presc_q;
  logic [7:0]  presc_nxt;
  logic        count_upd;
  logic        ti_q;
  logic        wr_count;
  logic        wr_compare;

  assign wr_count   = wr_en & (CP0_addr == A_COUNT);
  assign wr_compare = wr_en & (CP0_addr == A_COMPARE);

  // Next Count. A software load overrides the prescaled increment and restarts the prescaler.
  always_comb begin
    count_nxt = count_q;
    presc_nxt = presc_q + 8'd1;
    count_upd = 1'b0;
    if (wr_count) begin
      count_nxt = CP0_data_in;
      presc_nxt = 8'd0;
      count_upd = 1'b1;
    end else if (presc_q == PRESC_LAST) begin
      count_nxt = count_q + 32'd1;
      presc_nxt = 8'd0;
      count_upd = 1'b1;
    end
  end

  // Timer state. The match is checked only when Count actually takes a new value.
  // A Count that sits on Compare therefore cannot re-raise TI right after a Compare write.
  // A Compare write clears TI and beats a same-edge match.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '0;
      presc_q   <= '0;
      ti_q      <= 1'b0;
    end else begin
      count_q <= count_nxt;
      presc_q <= presc_nxt;
      if (wr_compare) begin
        compare_q <= CP0_data_in;
        ti_q      <= 1'b0;
      end else if (count_upd && (count_nxt == compare_q)) begin
        ti_q <= 1'b1;
      end
    end
  end

  assign ti         = ti_q;
  assign count_rd   = count_q;
  assign compare_rd = compare_q;
`else
  assign ti         = 1'b0;
  assign count_rd   = '0;
  assign compare_rd = '0;
`endif

  // mfc0 read mux. Unimplemented addresses read zero.
  always_comb begin
    CP0_data_out = '0;
    case (CP0_addr)
      A_COUNT:   CP0_data_out = count_rd;
      A_COMPARE: CP0_data_out = compare_rd;
      A_SR:      CP0_data_out = {16'b0, sr_q.im, 8'b0, sr_q.exl, sr_q.ie};
      A_CAUSE:   CP0_data_out = {cause_q.bd, ti, 14'b0, cause_q.ip, 3'b0,
                                 cause_q.exc_code, 2'b0};
      A_EPC:     CP0_data_out = epc_q;
      A_PRID:    CP0_data_out = PRID_VAL;
      default:   CP0_data_out = '0;
    endcase
  end

endmodule
